alu_rs: RTL
===========

# alu_rs

Reservation station for the ALU. Holds up to `RS_SIZE` dispatched integer/branch micro-ops, snoops both CDB buses to resolve pending operands, and each cycle issues at most one ready entry to the combinational ALU through registered outputs. It sits between the dispatch/decode stage and the ALU.

## Interface

**Parameters**
- `RS_SIZE`, 8: number of entries (power of two).
- `ROB_W`, 4: reorder-tag width.
- `OP_W`, 6: opcode width.
- `DATA_W`, 32: data/address width.

**Ports**
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Clear` input 1: synchronous flush on branch mispredict.
- `Issue_S` input 1: dispatch valid.
- `Issue_Op` input OP_W: opcode.
- `Issue_Vj` / `Issue_Vk` input DATA_W: operand values.
- `Issue_Qj_S` / `Issue_Qk_S` input 1: operand pending, waiting on a tag.
- `Issue_Qj` / `Issue_Qk` input ROB_W: producer tags.
- `Issue_Reorder` input ROB_W: destination ROB tag.
- `Issue_A` input DATA_W: immediate.
- `Issue_pc` input DATA_W: instruction PC.
- `RS_Full` output 1: no free entry; dispatch must hold `Issue_S` low.
- `CDB_ALU_S`, `CDB_ALU_Reorder`, `CDB_ALU_Value` inputs 1/ROB_W/DATA_W: ALU broadcast.
- `CDB_LSB_S`, `CDB_LSB_Reorder`, `CDB_LSB_Value` inputs 1/ROB_W/DATA_W: load/store broadcast.
- `ALU_S`, `Op`, `Vj`, `Vk`, `Reorder`, `A`, `pc` outputs 1/OP_W/DATA_W/DATA_W/ROB_W/DATA_W/DATA_W: registered request to the ALU.

## Operation

**Entry state.** Each entry holds `Busy`, Op, Vj, Vk, Qj_S, Qj, Qk_S, Qk, Reorder, A, pc.

**Dispatch.**
- When `Issue_S` is high and `Clear` is low, the lowest-index free entry is written.
- Same-cycle CDB bypass: if an incoming operand is pending and its tag matches a valid CDB tag this cycle, the entry stores the CDB value with Q_S=0.
- If both CDBs match, ALU has priority.

**Wakeup.** Every busy entry with Q*_S=1 compares its tag against both CDBs each cycle. On a match it latches the value and clears Q*_S at the edge.

**Ready.** An entry is ready when Busy=1, Qj_S=0 and Qk_S=0. An entry that becomes ready at edge k is selectable during cycle k.

**Select.**
- The lowest-index ready entry is chosen (fixed priority).
- At the edge, its fields are copied to the outputs, `ALU_S` is set to 1, and the entry's Busy is cleared.
- If no entry is ready, `ALU_S` is set to 0. The other outputs keep their values.

**`RS_Full`.** Combinational from registered Busy bits: all Busy=1. An entry leaving in the current cycle does not free space until the next cycle.

**`Clear`.** At the edge: all Busy←0, `ALU_S`←0, and any dispatch in that cycle is dropped.

**Reset.** While `rst_n`=0, asynchronously:
- all Busy, Q*_S and `ALU_S` are 0;
- `Op`, `Vj`, `Vk`, `Reorder`, `A`, `pc` are 0;
- `RS_Full` is 0.

**Ordering.** An entry never issues in the same cycle it is dispatched.

## Timing

- Dispatch with ready operands at edge k → `ALU_S`=1 after edge k+1 → the ALU result appears on the CDB in the same cycle → dependents capture it at edge k+2 → a dependent issues at edge k+3.
- Back-to-back dependent ALU ops therefore issue every 2 cycles.
- Throughput: one issue per cycle.
- `ALU_S` is high for exactly one cycle per issued entry.
- Simultaneous dispatch, wakeup and issue on different entries in one cycle are all honoured.
- A CDB match arriving in the entry's dispatch cycle is captured via bypass and is never lost.
- Reset deasserted mid-operation: the station resumes empty on the first edge after `rst_n` rises.

## Test plan

1. **Reset then single ready op.** Dispatch ADD with Vj=5, Vk=7, Reorder=3, no pending operands → one cycle later `ALU_S`=1, Op=ADD, Vj=5, Vk=7, Reorder=3; next cycle `ALU_S`=0.
2. **Wakeup.** Dispatch with Qj_S=1, Qj=2. Two cycles later pulse `CDB_LSB_S` with tag 2, value 0x10 → `ALU_S`=1 with Vj=0x10 exactly one cycle after the pulse.
3. **Dispatch-cycle bypass.** `Issue_Qk`=4 pending while `CDB_ALU_S`=1, tag 4, value 0xFF in the same cycle → entry issues the next cycle with Vk=0xFF.
4. **Full and priority.** Fill 8 entries all waiting on tag 1 → `RS_Full`=1. Broadcast tag 1 → entries issue one per cycle in index order 0..7; `RS_Full` drops the cycle after the first issue.
5. **Clear.** With 3 busy entries and a dispatch in the same cycle, pulse `Clear` → `ALU_S`=0 next cycle, `RS_Full`=0, and nothing issues afterward even if their tags broadcast.
6. **Async reset mid-issue.** Drop `rst_n` between edges while `ALU_S`=1 → `ALU_S`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: CDB-snooping entries, lowest-index ready entry issues at the next edge.
// Latency: dispatch-to-issue is one cycle for ready operands. Backpressure: RS_Full stalls dispatch, and the ALU never stalls issue.
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Clear,
    input  logic              Issue_S,
    input  logic [OP_W-1:0]   Issue_Op,
    input  logic [DATA_W-1:0] Issue_Vj,
    input  logic [DATA_W-1:0] Issue_Vk,
    input  logic              Issue_Qj_S,
    input  logic              Issue_Qk_S,
    input  logic [ROB_W-1:0]  Issue_Qj,
    input  logic [ROB_W-1:0]  Issue_Qk,
    input  logic [ROB_W-1:0]  Issue_Reorder,
    input  logic [DATA_W-1:0] Issue_A,
    input  logic [DATA_W-1:0] Issue_pc,
    output logic              RS_Full,
    input  logic              CDB_ALU_S,
    input  logic [ROB_W-1:0]  CDB_ALU_Reorder,
    input  logic [DATA_W-1:0] CDB_ALU_Value,
    input  logic              CDB_LSB_S,
    input  logic [ROB_W-1:0]  CDB_LSB_Reorder,
    input  logic [DATA_W-1:0] CDB_LSB_Value,
    output logic              ALU_S,
    output logic [OP_W-1:0]   Op,
    output logic [DATA_W-1:0] Vj,
    output logic [DATA_W-1:0] Vk,
    output logic [ROB_W-1:0]  Reorder,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] pc
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              qj_s;
        logic [ROB_W-1:0]  qj;
        logic              qk_s;
        logic [ROB_W-1:0]  qk;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] pc;
    } entry_t;

    entry_t           rs_q [RS_SIZE];
    entry_t           new_ent;
    logic             free_vld;
    logic [IDX_W-1:0] free_idx;
    logic             rdy_vld;
    logic [IDX_W-1:0] rdy_idx;

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        rdy_vld  = 1'b0;
        rdy_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!rs_q[i].busy) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (rs_q[i].busy && !rs_q[i].qj_s && !rs_q[i].qk_s) begin
                rdy_vld = 1'b1;
                rdy_idx = IDX_W'(i);
            end
        end
    end

    assign RS_Full = ~free_vld;

    // Incoming entry with same-cycle CDB bypass; the ALU bus wins a double match.
    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = Issue_Op;
        new_ent.vj   = Issue_Vj;
        new_ent.vk   = Issue_Vk;
        new_ent.qj_s = Issue_Qj_S;
        new_ent.qj   = Issue_Qj;
        new_ent.qk_s = Issue_Qk_S;
        new_ent.qk   = Issue_Qk;
        new_ent.rob  = Issue_Reorder;
        new_ent.a    = Issue_A;
        new_ent.pc   = Issue_pc;
        if (Issue_Qj_S) begin
            if (CDB_ALU_S && CDB_ALU_Reorder == Issue_Qj) begin
                new_ent.vj   = CDB_ALU_Value;
                new_ent.qj_s = 1'b0;
            end else if (CDB_LSB_S && CDB_LSB_Reorder == Issue_Qj) begin
                new_ent.vj   = CDB_LSB_Value;
                new_ent.qj_s = 1'b0;
            end
        end
        if (Issue_Qk_S) begin
            if (CDB_ALU_S && CDB_ALU_Reorder == Issue_Qk) begin
                new_ent.vk   = CDB_ALU_Value;
                new_ent.qk_s = 1'b0;
            end else if (CDB_LSB_S && CDB_LSB_Reorder == Issue_Qk) begin
                new_ent.vk   = CDB_LSB_Value;
                new_ent.qk_s = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) rs_q[i] <= '0;
            ALU_S   <= 1'b0;
            Op      <= '0;
            Vj      <= '0;
            Vk      <= '0;
            Reorder <= '0;
            A       <= '0;
            pc      <= '0;
        end else if (Clear) begin
            for (int i = 0; i < RS_SIZE; i++) rs_q[i].busy <= 1'b0;
            ALU_S <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (rs_q[i].busy && rs_q[i].qj_s) begin
                    if (CDB_ALU_S && CDB_ALU_Reorder == rs_q[i].qj) begin
                        rs_q[i].vj   <= CDB_ALU_Value;
                        rs_q[i].qj_s <= 1'b0;
                    end else if (CDB_LSB_S && CDB_LSB_Reorder == rs_q[i].qj) begin
                        rs_q[i].vj   <= CDB_LSB_Value;
                        rs_q[i].qj_s <= 1'b0;
                    end
                end
                if (rs_q[i].busy && rs_q[i].qk_s) begin
                    if (CDB_ALU_S && CDB_ALU_Reorder == rs_q[i].qk) begin
                        rs_q[i].vk   <= CDB_ALU_Value;
                        rs_q[i].qk_s <= 1'b0;
                    end else if (CDB_LSB_S && CDB_LSB_Reorder == rs_q[i].qk) begin
                        rs_q[i].vk   <= CDB_LSB_Value;
                        rs_q[i].qk_s <= 1'b0;
                    end
                end
            end
            // free_idx is never busy, so it cannot collide with rdy_idx.
            if (Issue_S && free_vld) rs_q[free_idx] <= new_ent;
            if (rdy_vld) begin
                rs_q[rdy_idx].busy <= 1'b0;
                ALU_S   <= 1'b1;
                Op      <= rs_q[rdy_idx].op;
                Vj      <= rs_q[rdy_idx].vj;
                Vk      <= rs_q[rdy_idx].vk;
                Reorder <= rs_q[rdy_idx].rob;
                A       <= rs_q[rdy_idx].a;
                pc      <= rs_q[rdy_idx].pc;
            end else begin
                ALU_S <= 1'b0;
            end
        end
    end
endmodule
